// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive/transmit blocks.
//   uart_rx_state_t  : receiver FSM state encoding
//   UART_DATA_BITS   : payload bits per frame (8N1)
//   UART_SYNC_STAGES : flops in the rxd metastability synchroniser
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head word and a registered empty flag.
// The head is not a fall-through: a push into an empty FIFO shows on dout and
// empty one cycle later.
// Ports:
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push     : write request, accepted when not full or when popping this cycle
//   din      : write data
//   full     : FIFO holds DEPTH entries
//   pop      : read request, ignored while empty
//   dout     : head entry (meaningful only while not empty)
//   empty    : registered "no entries" flag
//   count    : number of entries, one bit wider than the pointers
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_r;
    logic [WIDTH-1:0] dout_r;

    logic             pop_ok_s;
    logic             push_ok_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW:0]      count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign full      = (count_r == DEPTH_CNT);
    assign pop_ok_s  = pop && (count_r != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next pointers, occupancy and the word that becomes the head next cycle.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = dout_r;

        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase

        // The slot being written this cycle becomes the head only when it is
        // the sole remaining entry, so bypass din in that case.
        if (count_nxt_s == '0) begin
            head_nxt_s = dout_r;
        end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head/empty outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            dout_r   <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == '0);
            dout_r   <= head_nxt_s;
        end
    end

    assign dout  = dout_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/uart_rx_buf.sv
// -----------------------------------------------------------------------------
// uart_rx_buf
// Oversampling 8N1 UART receiver feeding a byte FIFO behind valid/ready.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts frame, flushes FIFO)
//   rxd       : asynchronous serial input, idles high
//   data      : FIFO head byte, meaningful while valid
//   valid     : FIFO not empty
//   ready     : consumer accepts; a byte is popped when valid && ready
//   frame_err : one-cycle pulse when a stop bit samples low
//   overflow  : sticky, a finished byte was dropped on a full FIFO
//   clr_ovf   : clears overflow (a same-cycle set wins)
//   busy      : receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_buf: CLKS_PER_BIT must be at least 4");
    end

    logic [UART_SYNC_STAGES-1:0] sync_r;
    logic                        rxd_s;
    uart_rx_state_t              state_r;
    uart_rx_state_t              state_nxt_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_nxt_s;
    logic [IDX_W-1:0]            idx_r;
    logic [IDX_W-1:0]            idx_nxt_s;
    logic [UART_DATA_BITS-1:0]   shift_r;
    logic [UART_DATA_BITS-1:0]   shift_nxt_s;
    logic                        push_s;
    logic                        ferr_nxt_s;
    logic                        frame_err_r;
    logic                        overflow_r;
    logic                        busy_r;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [FCW-1:0]              fifo_count_s;
    logic                        pop_s;
    logic                        drop_s;

    assign rxd_s = sync_r[UART_SYNC_STAGES-1];

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[UART_SYNC_STAGES-2:0], rxd};
        end
    end

    // Receiver next-state, counter, bit index and shift register update.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        push_s      = 1'b0;
        ferr_nxt_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = HALF_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == '0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!rxd_s) begin
                        state_nxt_s = DATA;
                        cnt_nxt_s   = FULL_LOAD;
                        idx_nxt_s   = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == '0) begin
                    shift_nxt_s = {rxd_s, shift_r[UART_DATA_BITS-1:1]};
                    cnt_nxt_s   = FULL_LOAD;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = STOP;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == '0) begin
                    if (rxd_s) begin
                        push_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        ferr_nxt_s  = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            BREAK: begin
                // Hold off until the line is released so a stuck-low line
                // cannot be mistaken for a stream of start bits.
                if (rxd_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
        end
    end

    assign pop_s  = ready && (fifo_count_s != '0);
    assign drop_s = push_s && fifo_full_s && !pop_s;

    // Registered status outputs; busy tracks the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= ferr_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (shift_r),
        .full  (fifo_full_s),
        .pop   (pop_s),
        .dout  (data),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign valid     = !fifo_empty_s;
    assign frame_err = frame_err_r;
    assign overflow  = overflow_r;
    assign busy      = busy_r;

endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

Oversampling UART receiver with an output byte FIFO. It sits directly downstream of the chip's `txd` pin. The simulation top level instantiates it to capture console output from `chip_top`, and FPGA builds reuse it as a host-side loopback/monitor. It recovers 8N1 frames from the serial line, flags framing errors and buffers received bytes behind a valid/ready interface.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clocks per bit (100 MHz / 115200). Legal range is ≥ 4; elaboration error otherwise.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `rxd`  in  1  asynchronous serial line; idles high.
- `data`  out  8  FIFO head byte; valid only while `valid` = 1.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts; pop occurs when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples 0.
- `overflow`  out  1  sticky; a completed byte was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `overflow`; a same-cycle set wins.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser whose flops reset to 1. All logic uses the synchronised value `rxd_s`.
- H = floor(CLKS_PER_BIT/2) and N = CLKS_PER_BIT. A down-counter `cnt` sized to $clog2(N).
- FSM states and transitions:
  - IDLE: when `rxd_s` = 0, load `cnt` = H−1 and go to START.
  - START: when `cnt` = 0, sample `rxd_s`.
    - Sample 0: load `cnt` = N−1, bit index = 0, go to DATA.
    - Sample 1: glitch; return to IDLE with no other effect.
  - DATA: when `cnt` = 0, shift `rxd_s` into the MSB of the shift register (LSB-first), reload N−1 and increment the bit index. After bit 7, go to STOP.
  - STOP: when `cnt` = 0, sample `rxd_s`.
    - Sample 1: push the shift register into the FIFO. If the FIFO is full and there is no same-cycle pop, drop the byte and set `overflow`. Go to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxd_s` = 1, then go to IDLE. This prevents a held-low line from restarting frames.
- FIFO behaviour:
  - `valid` = count ≠ 0; `data` = head entry.
  - A push into a full FIFO succeeds if a pop occurs in the same cycle.
  - Push into an empty FIFO: `data`/`valid` update the next cycle, with no fall-through.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count has one extra bit.
- Reset values:
  - FSM = IDLE; FIFO empty.
  - `valid` = 0, `data` = 0, `frame_err` = 0, `overflow` = 0, `busy` = 0.
  - Synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame. The partial byte is lost and FIFO contents are flushed.

## Timing
- Let the first low `rxd` be sampled at edge k.
  - `rxd_s` goes low after edge k+1.
  - IDLE→START at edge k+2.
  - Start-bit sample at edge k+2+H.
  - Data bit i sample at edge k+2+H+(i+1)·N.
  - Stop sample at edge k+2+H+9N.
- Latency: `valid`/`data` are visible in the cycle after the stop sample. `frame_err` is high for exactly that one cycle.
- Back-to-back frames: a start edge in the cycle after the stop sample is accepted. No idle gap beyond the stop-bit midpoint is required.
- Throughput: one pop per cycle. `ready` may toggle freely and has no combinational path to `data`.
- `busy` is registered and reflects the current FSM state.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`.
  - localparams `UART_DATA_BITS = 8`, `UART_SYNC_STAGES = 2`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): single-clock, synchronous active-high `rst`, with push/full and pop/empty/count ports. It is reused later by the UART TX path.
- The top module holds the synchroniser, counter, FSM and shift register.

## Test plan
All scenarios use CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
- Single frame 0xA5, `ready` = 1, first `rxd` low at edge k → `valid` rises at cycle k+155 with `data` = 0xA5; `frame_err` = 0; `busy` falls with the stop sample.
- Glitch: `rxd` low for 5 cycles, then high → no `valid`, no `frame_err`, FSM back to IDLE by edge k+11.
- Framing error: frame 0x3C with stop bit 0, line held low 40 cycles → one-cycle `frame_err`, FIFO stays empty, no new frame until `rxd` returns high.
- Overflow: five back-to-back frames 0x01..0x05 with `ready` = 0 → FIFO holds 0x01..0x04 and `overflow` = 1. Popping then yields 0x01..0x04 in order. `clr_ovf` clears `overflow`.
- Full FIFO with a pop in the same cycle as the 5th frame's stop sample → no overflow; the 0x05 byte is present after 0x02..0x04.
- Reset asserted during DATA bit 3 of 0x5A, with 2 bytes already queued → all outputs at reset values next cycle, FIFO empty. A following frame 0x77 is received correctly.
